// File: rtl/mm_compare_seq.sv
// Mastermind compare sequencer: steps the four secret pegs through the
// peg comparator one per cycle and captures the red/white score. It also
// keeps the game bookkeeping: guess count, win flag and game-over lockout.
`timescale 1ns/1ps
module mm_compare_seq #(
  parameter int unsigned MAX_GUESSES = 10
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        new_game,
  input  logic [11:0] code_in,
  input  logic [11:0] guess_in,
  input  logic [2:0]  red_in,
  input  logic [2:0]  white_in,
  output logic        cmp_resetn,
  output logic        compareEn,
  output logic [1:0]  compare_i,
  output logic [2:0]  curr_code,
  output logic [11:0] guess_out,
  output logic [2:0]  red_out,
  output logic [2:0]  white_out,
  output logic        done,
  output logic        win,
  output logic [3:0]  guess_count,
  output logic        game_over,
  output logic        busy
);

  localparam logic [4:0] MaxGuesses = 5'(MAX_GUESSES);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StCapture,
    StOver
  } state_t;

  state_t      r_state;
  logic        r_cmp_resetn;
  logic        r_compare_en;
  logic [1:0]  r_compare_i;
  logic [11:0] r_code_q;
  logic [11:0] r_guess;
  logic [2:0]  r_red;
  logic [2:0]  r_white;
  logic        r_done;
  logic        r_win;
  logic [3:0]  r_guess_count;

  logic [4:0]  w_count_inc;
  logic        w_last_guess;
  logic        w_red_win;
  logic [3:0]  w_count_sat;
  logic [2:0]  w_curr_code;

  // Guess-count arithmetic for the capture step.
  always_comb begin
    w_count_inc  = {1'b0, r_guess_count} + 5'd1;
    w_last_guess = (w_count_inc == MaxGuesses);
    w_red_win    = (red_in == 3'd4);
    w_count_sat  = (r_guess_count == 4'd15) ? 4'd15 : w_count_inc[3:0];
  end

  // Select the secret peg currently presented to the comparator.
  always_comb begin
    w_curr_code = r_code_q[2:0];
    unique case (r_compare_i)
      2'd0: w_curr_code = r_code_q[2:0];
      2'd1: w_curr_code = r_code_q[5:3];
      2'd2: w_curr_code = r_code_q[8:6];
      2'd3: w_curr_code = r_code_q[11:9];
      default: w_curr_code = r_code_q[2:0];
    endcase
  end

  // Sequencer FSM with registered comparator controls and score outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state       <= StIdle;
      r_cmp_resetn  <= 1'b0;
      r_compare_en  <= 1'b0;
      r_compare_i   <= 2'd0;
      r_code_q      <= 12'd0;
      r_guess       <= 12'd0;
      r_red         <= 3'd0;
      r_white       <= 3'd0;
      r_done        <= 1'b0;
      r_win         <= 1'b0;
      r_guess_count <= 4'd0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_cmp_resetn <= 1'b1;
          if (new_game) begin
            // new_game wins over a simultaneous start; the start is dropped.
            r_guess_count <= 4'd0;
            r_win         <= 1'b0;
          end else if (start) begin
            r_code_q     <= code_in;
            r_guess      <= guess_in;
            r_cmp_resetn <= 1'b0;
            r_state      <= StClear;
          end
        end
        StClear: begin
          r_cmp_resetn <= 1'b1;
          r_compare_en <= 1'b1;
          r_compare_i  <= 2'd0;
          r_state      <= StRun;
        end
        StRun: begin
          if (r_compare_i == 2'd3) begin
            r_compare_en <= 1'b0;
            r_compare_i  <= 2'd0;
            r_state      <= StCapture;
          end else begin
            r_compare_i <= r_compare_i + 2'd1;
          end
        end
        StCapture: begin
          // Comparator registered its last update at the final RUN edge.
          r_red         <= red_in;
          r_white       <= white_in;
          r_done        <= 1'b1;
          r_guess_count <= w_count_sat;
          if (w_red_win) begin
            r_win <= 1'b1;
          end
          r_state <= (w_red_win || w_last_guess) ? StOver : StIdle;
        end
        StOver: begin
          r_cmp_resetn <= 1'b1;
          if (new_game) begin
            r_guess_count <= 4'd0;
            r_win         <= 1'b0;
            r_state       <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Output wiring.
  always_comb begin
    cmp_resetn  = r_cmp_resetn;
    compareEn   = r_compare_en;
    compare_i   = r_compare_i;
    curr_code   = w_curr_code;
    guess_out   = r_guess;
    red_out     = r_red;
    white_out   = r_white;
    done        = r_done;
    win         = r_win;
    guess_count = r_guess_count;
    game_over   = (r_state == StOver);
    busy        = (r_state == StClear) || (r_state == StRun) || (r_state == StCapture);
  end

endmodule

// File: tb/tb_mm_compare_seq.sv
// Bench for mm_compare_seq paired with a behavioural peg comparator.
// Expected scores are queued at issue time and checked when done pulses.
`timescale 1ns/1ps
module tb_mm_compare_seq;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        new_game;
  logic [11:0] code_in;
  logic [11:0] guess_in;
  logic [2:0]  red_in;
  logic [2:0]  white_in;
  logic        cmp_resetn;
  logic        compareEn;
  logic [1:0]  compare_i;
  logic [2:0]  curr_code;
  logic [11:0] guess_out;
  logic [2:0]  red_out;
  logic [2:0]  white_out;
  logic        done;
  logic        win;
  logic [3:0]  guess_count;
  logic        game_over;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [2:0] red;
    logic [2:0] white;
    logic       win;
    logic       over;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  mm_compare_seq #(.MAX_GUESSES(3)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .new_game    (new_game),
    .code_in     (code_in),
    .guess_in    (guess_in),
    .red_in      (red_in),
    .white_in    (white_in),
    .cmp_resetn  (cmp_resetn),
    .compareEn   (compareEn),
    .compare_i   (compare_i),
    .curr_code   (curr_code),
    .guess_out   (guess_out),
    .red_out     (red_out),
    .white_out   (white_out),
    .done        (done),
    .win         (win),
    .guess_count (guess_count),
    .game_over   (game_over),
    .busy        (busy)
  );

  // Comparator model (valid for codes and guesses with distinct pegs).
  function automatic logic white_hit(input logic [11:0] g, input logic [1:0] idx,
                                     input logic [2:0] c);
    for (int j = 0; j < 4; j++) begin
      if (j != int'(idx) && g[3*j +: 3] == c) return 1'b1;
    end
    return 1'b0;
  endfunction

  logic [2:0] m_red   = 3'd0;
  logic [2:0] m_white = 3'd0;

  always @(posedge clock) begin
    if (!cmp_resetn) begin
      m_red   <= 3'd0;
      m_white <= 3'd0;
    end else if (compareEn) begin
      if (guess_out[3*compare_i +: 3] == curr_code) m_red <= m_red + 3'd1;
      else if (white_hit(guess_out, compare_i, curr_code)) m_white <= m_white + 3'd1;
    end
  end

  assign red_in   = m_red;
  assign white_in = m_white;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (resetn === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("red_out", 32'(red_out), 32'(e.red));
        chk("white_out", 32'(white_out), 32'(e.white));
        chk("win", 32'(win), 32'(e.win));
        chk("game_over", 32'(game_over), 32'(e.over));
        chk("guess_count", 32'(guess_count), 32'(e.cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [2:0] r, input logic [2:0] w, input logic wn,
                      input logic ov, input logic [3:0] c);
    exp_t e;
    e.red = r; e.white = w; e.win = wn; e.over = ov; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [11:0] c, input logic [11:0] g);
    code_in  = c;
    guess_in = g;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wait_done();
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    new_game = 1'b0;
    code_in  = 12'd0;
    guess_in = 12'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_cmp_resetn", 32'(cmp_resetn), 32'd0);
    chk("rst_compareEn", 32'(compareEn), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_guess_count", 32'(guess_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    tick();

    // A: exact match, with per-cycle latency and peg order checks.
    code_in  = 12'o1234;
    guess_in = 12'o1234;
    start    = 1'b1;
    push(3'd4, 3'd0, 1'b1, 1'b1, 4'd1);
    tick();
    start = 1'b0;
    @(negedge clock);
    chk("clear_cmp_resetn", 32'(cmp_resetn), 32'd0);
    chk("clear_busy", 32'(busy), 32'd1);
    chk("clear_compareEn", 32'(compareEn), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("run_compare_i", 32'(compare_i), 32'(i));
      chk("run_curr_code", 32'(curr_code), 32'(4 - i));
      chk("run_compareEn", 32'(compareEn), 32'd1);
    end
    @(negedge clock);
    chk("capture_compareEn", 32'(compareEn), 32'd0);
    chk("capture_done", 32'(done), 32'd0);
    @(negedge clock);
    chk("latency_done", 32'(done), 32'd1);
    tick();
    do_new_game();
    @(negedge clock);
    chk("ng_game_over", 32'(game_over), 32'd0);
    chk("ng_guess_count", 32'(guess_count), 32'd0);
    chk("ng_win", 32'(win), 32'd0);
    tick();

    // B, C: non-winning guesses.
    push(3'd0, 3'd4, 1'b0, 1'b0, 4'd1);
    issue(12'o1234, 12'o4321);
    tick();
    push(3'd2, 3'd2, 1'b0, 1'b0, 4'd2);
    issue(12'o1234, 12'o1243);
    tick();

    // D: new_game beats a simultaneous start.
    start    = 1'b1;
    new_game = 1'b1;
    tick();
    start    = 1'b0;
    new_game = 1'b0;
    @(negedge clock);
    chk("prio_guess_count", 32'(guess_count), 32'd0);
    chk("prio_busy", 32'(busy), 32'd0);
    tick();

    // E: three misses reach the limit; start pulse during RUN is ignored.
    code_in  = 12'o1234;
    guess_in = 12'o4321;
    start    = 1'b1;
    push(3'd0, 3'd4, 1'b0, 1'b0, 4'd1);
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    tick();
    push(3'd0, 3'd4, 1'b0, 1'b0, 4'd2);
    issue(12'o1234, 12'o2143);
    tick();
    push(3'd2, 3'd2, 1'b0, 1'b1, 4'd3);
    issue(12'o1234, 12'o1243);
    tick();
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("over_busy", 32'(busy), 32'd0);
      chk("over_game_over", 32'(game_over), 32'd1);
    end
    start = 1'b0;
    tick();
    do_new_game();
    @(negedge clock);
    chk("over_ng_count", 32'(guess_count), 32'd0);
    chk("over_ng_game_over", 32'(game_over), 32'd0);
    tick();
    push(3'd2, 3'd2, 1'b0, 1'b0, 4'd1);
    issue(12'o1234, 12'o1324);
    tick();

    // F: reset mid-guess aborts with no done.
    code_in  = 12'o1234;
    guess_in = 12'o4321;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    resetn = 1'b0;
    tick();
    @(negedge clock);
    chk("mid_rst_cmp_resetn", 32'(cmp_resetn), 32'd0);
    chk("mid_rst_compareEn", 32'(compareEn), 32'd0);
    chk("mid_rst_compare_i", 32'(compare_i), 32'd0);
    chk("mid_rst_guess_out", 32'(guess_out), 32'd0);
    chk("mid_rst_red_out", 32'(red_out), 32'd0);
    chk("mid_rst_white_out", 32'(white_out), 32'd0);
    chk("mid_rst_guess_count", 32'(guess_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    resetn = 1'b1;
    @(negedge clock);
    chk("mid_rst_cmp_red", 32'(red_in), 32'd0);
    chk("mid_rst_cmp_white", 32'(white_in), 32'd0);
    repeat (8) tick();

    // G: start held high; back-to-back guesses score independently.
    code_in  = 12'o1234;
    guess_in = 12'o1243;
    push(3'd2, 3'd2, 1'b0, 1'b0, 4'd1);
    push(3'd2, 3'd2, 1'b0, 1'b0, 4'd2);
    start = 1'b1;
    wait_done();
    @(negedge clock);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done();
    start = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("b2b_idle_busy", 32'(busy), 32'd0);
    end

    repeat (3) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
